// File: rtl/stream_mux_n_to_1.sv
// N-input valid/ready stream mux with a packet-locking arbiter (fixed priority or
// round-robin) feeding a single-entry registered output stage.
module stream_mux_n_to_1 #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SW    = $clog2(N)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] InData,
    input  logic [N-1:0]       InValid,
    input  logic [N-1:0]       InLast,
    output logic [N-1:0]       InReady,
    output logic [WIDTH-1:0]   Out,
    output logic               OutLast,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [SW-1:0]      Sel
);

    typedef enum logic {ARB, HOLD} state_t;

    state_t           state;
    logic [SW-1:0]    cur;
    logic [SW-1:0]    ptr;
    logic [N-1:0]     grant;
    logic             found;
    logic [SW-1:0]    gidx;
    logic [WIDTH-1:0] gdata;
    logic             glast;
    logic             load;
    logic             xfer;

    assign load = !OutValid || OutReady;

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (state == HOLD) begin
            for (int unsigned k = 0; k < N; k++)
                grant[k] = (SW'(k) == cur);
        end else if (MODE == 0) begin
            for (int unsigned k = 0; k < N; k++)
                if (!found && InValid[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
        end else begin
            // Rotating search from ptr+1: indices above ptr first, then wrap to 0..ptr.
            for (int unsigned k = 0; k < N; k++)
                if (!found && InValid[k] && (SW'(k) > ptr)) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            for (int unsigned k = 0; k < N; k++)
                if (!found && InValid[k] && (SW'(k) <= ptr)) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
        end
    end

    always_comb begin
        gidx  = '0;
        gdata = '0;
        glast = 1'b0;
        for (int unsigned k = 0; k < N; k++)
            if (grant[k]) begin
                gidx  = SW'(k);
                gdata = InData[k*WIDTH +: WIDTH];
                glast = InLast[k];
            end
    end

    assign xfer    = load && |(grant & InValid);
    assign InReady = (load && !Reset) ? grant : '0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ARB;
            cur      <= '0;
            ptr      <= SW'(N - 1);
            OutValid <= 1'b0;
            Out      <= '0;
            OutLast  <= 1'b0;
            Sel      <= '0;
        end else if (load) begin
            if (xfer) begin
                Out      <= gdata;
                OutLast  <= glast;
                Sel      <= gidx;
                OutValid <= 1'b1;
                if (glast) begin
                    state <= ARB;
                    ptr   <= gidx;
                end else begin
                    state <= HOLD;
                    cur   <= gidx;
                end
            end else begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Scoreboard bench: one DUT per arbitration mode, random packets and backpressure,
// checked against a transaction-level arbitration model.
module tb_stream_mux_n_to_1;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int SW   = $clog2(N);
    localparam int NCYC = 3000;

    typedef struct packed {
        logic [W-1:0]  d;
        logic          l;
        logic [SW-1:0] s;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } word_t;

    // kind 0: InReady check, 1: post-reset output check, 2: end-of-run drain check
    typedef struct packed {
        logic [1:0]   kind;
        logic [N-1:0] ready;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[2][$];
    chk_t cq[2][$];

    for (genvar m = 0; m < 2; m++) begin : g_mode
        logic             rst;
        logic [N*W-1:0]   in_data;
        logic [N-1:0]     in_valid;
        logic [N-1:0]     in_last;
        logic [N-1:0]     in_ready;
        logic [W-1:0]     out_q;
        logic             out_last;
        logic             out_valid;
        logic             out_ready;
        logic [SW-1:0]    sel;
        bit               done = 1'b0;
        word_t            src[N][$];

        stream_mux_n_to_1 #(.WIDTH(W), .N(N), .MODE(m)) dut (
            .Clock   (clk),
            .Reset   (rst),
            .InData  (in_data),
            .InValid (in_valid),
            .InLast  (in_last),
            .InReady (in_ready),
            .Out     (out_q),
            .OutLast (out_last),
            .OutValid(out_valid),
            .OutReady(out_ready),
            .Sel     (sel)
        );

        initial begin : stim
            int           m_lock, m_ptr, g, pv, pr, mid_rst, len;
            bit           m_ov, ld, xfer, prev_rst, drain;
            logic [N-1:0] keep, midpkt, er;
            exp_t         e;
            chk_t         c;
            word_t        w;

            rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
            keep = '0; midpkt = '0; prev_rst = 1'b0;
            m_ov = 1'b0; m_lock = -1; m_ptr = N - 1;
            mid_rst = 1500 + $urandom_range(0, 200);

            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(posedge clk); #1;
                rst   = (cyc < 2) || (cyc == mid_rst);
                drain = (cyc >= NCYC - 60);
                if (cyc < 600)       begin pv = 100; pr = 100; end
                else if (cyc < 1800) begin pv = 60;  pr = 75;  end
                else                 begin pv = 40;  pr = 35;  end
                if (drain) pr = 100;
                for (int k = 0; k < N; k++) begin
                    if (src[k].size() == 0) begin
                        len = $urandom_range(1, 4);
                        for (int j = 0; j < len; j++) begin
                            w.d = W'($urandom);
                            w.l = (j == len - 1);
                            src[k].push_back(w);
                        end
                    end
                    if (!keep[k])
                        in_valid[k] = drain ? midpkt[k] : ($urandom_range(0, 99) < pv);
                    in_data[k*W +: W] = src[k][0].d;
                    in_last[k]        = src[k][0].l;
                end
                out_ready = ($urandom_range(0, 99) < pr);
                #1;

                if (prev_rst) begin
                    c.kind = 2'd1; c.ready = '0;
                    cq[m].push_back(c);
                end
                if (rst) begin
                    c.kind = 2'd0; c.ready = '0;
                    cq[m].push_back(c);
                    m_ov = 1'b0; m_lock = -1; m_ptr = N - 1;
                    sb[m].delete();
                    keep = '0; midpkt = '0;
                end else begin
                    ld = !m_ov || out_ready;
                    g  = -1;
                    if (m_lock >= 0) g = m_lock;
                    else if (m == 0) begin
                        for (int i = 0; i < N; i++)
                            if (g < 0 && in_valid[i]) g = i;
                    end else begin
                        for (int i = 1; i <= N; i++)
                            if (g < 0 && in_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                    end
                    er = '0;
                    if (ld && g >= 0) er[g] = 1'b1;
                    c.kind = 2'd0; c.ready = er;
                    cq[m].push_back(c);
                    xfer = ld && (g >= 0) && in_valid[g];
                    keep = in_valid;
                    if (xfer) begin
                        keep[g]   = 1'b0;
                        e.d       = src[g][0].d;
                        e.l       = src[g][0].l;
                        e.s       = SW'(g);
                        sb[m].push_back(e);
                        midpkt[g] = !src[g][0].l;
                        if (src[g][0].l) begin
                            m_lock = -1;
                            m_ptr  = g;
                        end else begin
                            m_lock = g;
                        end
                        void'(src[g].pop_front());
                        m_ov = 1'b1;
                    end else if (ld) begin
                        m_ov = 1'b0;
                    end
                end
                prev_rst = rst;
            end

            @(posedge clk); #1;
            rst = 1'b0; in_valid = '0; out_ready = 1'b1;
            #1;
            c.kind = 2'd2; c.ready = '0;
            cq[m].push_back(c);
            done = 1'b1;
        end
    end

    task automatic check_mode(input int m, input logic r, input logic ov, input logic ordy,
                              input logic [W-1:0] oq, input logic ol, input logic [SW-1:0] s,
                              input logic [N-1:0] ir);
        exp_t e;
        chk_t c;
        if (!r && ov && ordy) begin
            compared++;
            if (sb[m].size() == 0) begin
                mismatched++;
                $display("FAIL mode%0d unexpected_output: got data=%h last=%b sel=%0d, required none queued",
                         m, oq, ol, s);
            end else begin
                e = sb[m].pop_front();
                if ({oq, ol, s} !== {e.d, e.l, e.s}) begin
                    mismatched++;
                    $display("FAIL mode%0d output_word @%0t: got data=%h last=%b sel=%0d, required data=%h last=%b sel=%0d",
                             m, $time, oq, ol, s, e.d, e.l, e.s);
                end
            end
        end
        while (cq[m].size() > 0) begin
            c = cq[m].pop_front();
            compared++;
            case (c.kind)
                2'd0: if (ir !== c.ready) begin
                    mismatched++;
                    $display("FAIL mode%0d in_ready @%0t: got %b, required %b", m, $time, ir, c.ready);
                end
                2'd1: if ({ov, ol, s, oq} !== '0) begin
                    mismatched++;
                    $display("FAIL mode%0d reset_outputs: got valid=%b last=%b sel=%0d data=%h, required all zero",
                             m, ov, ol, s, oq);
                end
                default: if (sb[m].size() != 0) begin
                    mismatched++;
                    $display("FAIL mode%0d drain_residual: got %0d words outstanding, required 0", m, sb[m].size());
                end
            endcase
        end
    endtask

    always @(negedge clk) begin
        check_mode(0, g_mode[0].rst, g_mode[0].out_valid, g_mode[0].out_ready, g_mode[0].out_q,
                   g_mode[0].out_last, g_mode[0].sel, g_mode[0].in_ready);
        check_mode(1, g_mode[1].rst, g_mode[1].out_valid, g_mode[1].out_ready, g_mode[1].out_q,
                   g_mode[1].out_last, g_mode[1].sel, g_mode[1].in_ready);
    end

    initial begin
        while (!(g_mode[0].done && g_mode[1].done)) @(posedge clk);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stream_mux_n_to_1.md
# stream_mux_n_to_1

Parametrised N-input, WIDTH-bit multiplexer that merges N valid/ready input streams onto one registered output stream. Selection is no longer driven by an external `Sel`. An internal arbiter (fixed-priority or round-robin) picks the source, holds the grant for the whole packet delimited by `InLast`, and reports the chosen channel on `Sel`. It sits wherever several producers share one consumer, and it replaces the combinational 4-to-1 mux in datapaths that need flow control.

## Interface
- `WIDTH`, 8: data width per channel.
- `N`, 4: number of input channels, 2..16.
- `MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `SW`, $clog2(N): width of `Sel`. Derived; do not override.
- `Clock`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `InData`, in, N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `InValid`, in, N: per-channel valid.
- `InLast`, in, N: per-channel end-of-packet marker, qualified by `InValid`.
- `InReady`, out, N: per-channel ready; at most one bit is set.
- `Out`, out, WIDTH: registered output data.
- `OutLast`, out, 1: registered copy of the accepted word's `InLast`.
- `OutValid`, out, 1: output register holds a word.
- `OutReady`, in, 1: consumer accepts when `OutValid` and `OutReady` are both 1.
- `Sel`, out, SW: channel index of the word currently in the output register.

## Operation
- Output stage is a single-entry register.
  - `load = !OutValid | OutReady`.
  - A transfer on channel g happens when `load & InValid[g] & grant[g]`. On a transfer, `Out`, `OutLast` and `Sel` are loaded from channel g and `OutValid` is set to 1.
  - If `load` is 1 and there is no transfer, `OutValid` goes to 0.
  - If `load` is 0, all output registers hold.
- `InReady[g] = load & grant[g]`. `grant` is one-hot or zero, and is combinational from state, `InValid` and the RR pointer.
- The state machine has two states, ARB and HOLD, plus a register `Cur` (SW bits).
  - **ARB**:
    - `grant` is the arbitration winner among the set `InValid` bits. With no valid input, `grant` is 0.
    - On a transfer with `InLast[g]=0`: go to HOLD and set `Cur=g`.
    - On a transfer with `InLast[g]=1`: stay in ARB. This is a single-word packet.
  - **HOLD**:
    - `grant = onehot(Cur)` regardless of other valids. Other channels see `InReady=0`.
    - A transfer with `InLast[Cur]=1` returns the FSM to ARB.
    - A transfer with `InLast=0`, or no transfer, stays in HOLD.
- Arbitration:
  - MODE 0: the lowest set index of `InValid` wins.
  - MODE 1: search starts at `Ptr+1` and wraps modulo N. Index N-1 wraps to 0.
- `Ptr` register (SW bits, MODE 1 only):
  - Set to the granted channel when that channel's last word transfers.
  - Never updated mid-packet.
  - Ignored in MODE 0.
- Reset (synchronous) values:
  - State=ARB, `Cur`=0, `Ptr`=N-1 so that channel 0 has first priority.
  - `OutValid`=0, `Out`=0, `OutLast`=0, `Sel`=0.
  - `InReady` reads 0 only while `Reset` is asserted and in the same cycle.
  - A packet in progress is abandoned. No partial recovery.
- Boundary cases:
  - Output full and stalled (`OutValid=1`, `OutReady=0`): `load=0`, all `InReady`=0, and `Out`/`OutLast`/`Sel` stay stable.
  - Simultaneous drain and fill (`OutValid=1`, `OutReady=1`, a granted valid present): the new word loads in the same edge, so there is no bubble.
  - Channel drops `InValid` in HOLD: no transfer, the grant is kept, and the output empties once drained.
  - Only one channel valid in MODE 1: that channel wins regardless of `Ptr`.

## Timing
- Latency is 1 cycle. A word accepted at edge t is visible on `Out` with `OutValid=1` after edge t.
- Throughput is 1 word/cycle while `OutReady=1` and the granted source stays valid.
- Combinational paths:
  - `OutReady` → `InReady` is combinational. This is the only comb path from the sink side.
  - `InValid` → `InReady` is combinational in ARB.
  - No comb path from `InData` to any output.
- Handshake rules:
  - Sources must hold `InData`/`InLast` stable while `InValid=1` and `InReady=0`.
  - The block holds `Out`/`OutLast`/`Sel` stable while `OutValid=1` and `OutReady=0`.
- Grant changes take effect on the first cycle after the `InLast` transfer. A new winner can transfer in that cycle.

## Test plan
1. **Reset check.** Settings: N=4, WIDTH=8, MODE=1. Assert `Reset` for 2 cycles with all `InValid=1`. Required: `OutValid=0`, `Out=0x00`, `Sel=0`, `InReady=0000`. On the first cycle after reset, ch0 is granted.
2. **Round-robin fairness.** Settings: MODE=1, all four channels always valid, single-word packets (`InLast=1111`), ch k data = 0x10+k, `OutReady=1`. Required: `Sel` sequence 0,1,2,3,0,1 and `Out` 0x10,0x11,0x12,0x13,0x10 with no bubbles.
3. **Fixed priority.** Settings: MODE=0, `InValid=0110`, `InLast=1111`. Required: ch1 wins every cycle (`Out`=0x11 repeated). ch2 gets `InReady=0` throughout.
4. **Packet lock.**
   - Setup: MODE=1. ch2 sends 3 words (0xA0,0xA1,0xA2, last on the third) while ch0 is continuously valid.
   - Required: `Sel`=2 for three consecutive outputs, then `Sel`=3 if ch3 is valid, otherwise ch0.
   - Required: ch0 `InReady=0` during the packet.
5. **Backpressure.** Hold `OutReady=0` for 5 cycles while `OutValid=1` with `Out`=0x42. Required: `Out`, `Sel`, `OutLast` stable and all `InReady=0`. When `OutReady` rises, the next word loads on the same edge.
6. **Reset mid-packet.** Assert `Reset` after word 2 of a 4-word ch1 packet. Required: state returns to ARB, `OutValid=0`, and ch0 is granted next.
